delay_ram_write_arbiter: RTL

Merges the four per-channel delay-RAM write streams from the UART receive path onto one shared write port of a unified delay RAM. The unified RAM is 4 x 2K words of 24 bits, addressed {channel, wave ID}. Each channel has a one-entry holding slot. A round-robin arbiter drains the slots when the RAM port signals ready. The block sits between the UART frame decoder and the delay RAM.

---
 rtl/delay_ram_write_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/delay_ram_write_arbiter.sv
// delay_ram_write_arbiter
//   Merges four per-channel delay-RAM write streams onto the single write port
//   of a unified 4 x 2^ADDR_W delay RAM addressed {channel, wave ID}.
//   Each channel owns a one-entry holding slot; a round-robin arbiter drains
//   pending slots whenever the RAM port reports ready.
//
// Ports
//   I_clk_10M                 system clock
//   I_rst                     synchronous active-high reset
//   I_WEA_RAMn                per-channel write strobe (one write per high cycle)
//   I_WRITE_ADDR_RAMn         per-channel wave ID
//   I_WRITE_DELAY_RAMn        per-channel delay word
//   I_RAM_READY               shared port may accept a write this cycle
//   I_OVF_CLR                 clears the sticky overflow flags
//   O_WEA                     one-cycle write pulse to the shared RAM
//   O_WRITE_ADDR              {channel[1:0], wave ID}
//   O_WRITE_DELAY             write data
//   O_OVF                     sticky per-channel overflow, bit0 = RAM1
//   O_BUSY                    at least one slot pending
module delay_ram_write_arbiter #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 24
) (
  input  logic              I_clk_10M,
  input  logic              I_rst,
  input  logic              I_WEA_RAM1,
  input  logic              I_WEA_RAM2,
  input  logic              I_WEA_RAM3,
  input  logic              I_WEA_RAM4,
  input  logic [ADDR_W-1:0] I_WRITE_ADDR_RAM1,
  input  logic [ADDR_W-1:0] I_WRITE_ADDR_RAM2,
  input  logic [ADDR_W-1:0] I_WRITE_ADDR_RAM3,
  input  logic [ADDR_W-1:0] I_WRITE_ADDR_RAM4,
  input  logic [DATA_W-1:0] I_WRITE_DELAY_RAM1,
  input  logic [DATA_W-1:0] I_WRITE_DELAY_RAM2,
  input  logic [DATA_W-1:0] I_WRITE_DELAY_RAM3,
  input  logic [DATA_W-1:0] I_WRITE_DELAY_RAM4,
  input  logic              I_RAM_READY,
  input  logic              I_OVF_CLR,
  output logic              O_WEA,
  output logic [ADDR_W+1:0] O_WRITE_ADDR,
  output logic [DATA_W-1:0] O_WRITE_DELAY,
  output logic [3:0]        O_OVF,
  output logic              O_BUSY
);

  typedef enum logic {StEmpty, StFull} slot_st_e;

  logic [3:0]        wea_in;
  logic [ADDR_W-1:0] addr_in [4];
  logic [DATA_W-1:0] data_in [4];

  assign wea_in     = {I_WEA_RAM4, I_WEA_RAM3, I_WEA_RAM2, I_WEA_RAM1};
  assign addr_in[0] = I_WRITE_ADDR_RAM1;
  assign addr_in[1] = I_WRITE_ADDR_RAM2;
  assign addr_in[2] = I_WRITE_ADDR_RAM3;
  assign addr_in[3] = I_WRITE_ADDR_RAM4;
  assign data_in[0] = I_WRITE_DELAY_RAM1;
  assign data_in[1] = I_WRITE_DELAY_RAM2;
  assign data_in[2] = I_WRITE_DELAY_RAM3;
  assign data_in[3] = I_WRITE_DELAY_RAM4;

  slot_st_e          slot_st_q   [4];
  slot_st_e          slot_st_d   [4];
  logic [ADDR_W-1:0] slot_addr_q [4];
  logic [ADDR_W-1:0] slot_addr_d [4];
  logic [DATA_W-1:0] slot_data_q [4];
  logic [DATA_W-1:0] slot_data_d [4];

  logic [1:0]        last_grant_q, last_grant_d;
  logic [3:0]        ovf_q, ovf_d;
  logic              wea_q, wea_d;
  logic [ADDR_W+1:0] addr_out_q, addr_out_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              busy_q, busy_d;

  logic [3:0] pending;
  logic       grant_vld;
  logic [1:0] grant_ch;
  logic [3:0] grant_oh;
  logic [1:0] cand;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      pending[n] = (slot_st_q[n] == StFull);
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = last_grant_q;
    grant_oh  = '0;
    cand      = '0;
    if (I_RAM_READY) begin
      for (int k = 1; k <= 4; k++) begin
        cand = last_grant_q + 2'(k);
        if (!grant_vld && pending[cand]) begin
          grant_vld = 1'b1;
          grant_ch  = cand;
        end
      end
    end
    if (grant_vld) begin
      grant_oh[grant_ch] = 1'b1;
    end
  end

  // A granted slot is free to take a new write in the same cycle (refill).
  always_comb begin
    ovf_d = ovf_q & ~{4{I_OVF_CLR}};
    for (int n = 0; n < 4; n++) begin
      slot_st_d[n]   = slot_st_q[n];
      slot_addr_d[n] = slot_addr_q[n];
      slot_data_d[n] = slot_data_q[n];
      if (wea_in[n]) begin
        if (slot_st_q[n] == StEmpty || grant_oh[n]) begin
          slot_st_d[n]   = StFull;
          slot_addr_d[n] = addr_in[n];
          slot_data_d[n] = data_in[n];
        end else begin
          ovf_d[n] = 1'b1;  // set wins over a simultaneous clear
        end
      end else if (grant_oh[n]) begin
        slot_st_d[n] = StEmpty;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    wea_d        = grant_vld;
    addr_out_d   = addr_out_q;
    data_out_d   = data_out_q;
    busy_d       = 1'b0;
    if (grant_vld) begin
      last_grant_d = grant_ch;
      addr_out_d   = {grant_ch, slot_addr_q[grant_ch]};
      data_out_d   = slot_data_q[grant_ch];
    end
    for (int n = 0; n < 4; n++) begin
      if (slot_st_d[n] == StFull) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge I_clk_10M) begin
    if (I_rst) begin
      for (int n = 0; n < 4; n++) begin
        slot_st_q[n]   <= StEmpty;
        slot_addr_q[n] <= '0;
        slot_data_q[n] <= '0;
      end
      last_grant_q <= 2'd3;  // ch0 wins the first arbitration
      ovf_q        <= '0;
      wea_q        <= 1'b0;
      addr_out_q   <= '0;
      data_out_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        slot_st_q[n]   <= slot_st_d[n];
        slot_addr_q[n] <= slot_addr_d[n];
        slot_data_q[n] <= slot_data_d[n];
      end
      last_grant_q <= last_grant_d;
      ovf_q        <= ovf_d;
      wea_q        <= wea_d;
      addr_out_q   <= addr_out_d;
      data_out_q   <= data_out_d;
      busy_q       <= busy_d;
    end
  end

  assign O_WEA         = wea_q;
  assign O_WRITE_ADDR  = addr_out_q;
  assign O_WRITE_DELAY = data_out_q;
  assign O_OVF         = ovf_q;
  assign O_BUSY        = busy_q;

endmodule
